// File: rtl/inv_mix_columns_seq.sv
//------------------------------------------------------------------------------
// inv_mix_columns_seq
//
// Sequential AES InvMixColumns stage for the decryption round. It sits between
// InvShiftRows/InvSubBytes and AddRoundKey. One 128-bit state is accepted
// through a valid/ready handshake and copied into a working register. The
// columns are then transformed in place, COLS_PER_CYCLE columns per clock, and
// the result is offered through an output valid/ready handshake.
//
// Byte layout (for both din and dout):
//   column k = [32k+31:32k]
//   row 0    = [32k+31:32k+24]
//   row 3    = [32k+7:32k]
//
// Parameters
//   COLS_PER_CYCLE : columns transformed per CALC cycle. Legal values are 1, 2
//                    and 4; any other value stops elaboration.
//
// Ports
//   i_clk       : rising-edge clock
//   i_rst_n     : asynchronous active-low reset
//   i_in_valid  : i_din carries a state to transform
//   o_in_ready  : block can accept a state (high only in IDLE)
//   i_din       : input state
//   o_out_valid : o_dout holds a completed result
//   i_out_ready : downstream accepts o_dout
//   o_dout      : transformed state, driven straight from the working register
//   o_busy      : high while in CALC or DONE
//------------------------------------------------------------------------------
module inv_mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [127:0] i_din,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [127:0] o_dout,
   output logic         o_busy
);

   // Reject unsupported column rates at elaboration time.
   generate
      if ((COLS_PER_CYCLE != 1) && (COLS_PER_CYCLE != 2) && (COLS_PER_CYCLE != 4)) begin : g_bad_cols_per_cycle
         $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   // The column counter is 2 bits wide, so the step wraps naturally. With
   // four columns per cycle the step is 0 and the counter stays at 0.
   localparam logic [1:0] COL_STEP     = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_COL_CNT = 2'(4 - COLS_PER_CYCLE);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t       r_state;
   logic [1:0]   r_col_cnt;
   logic [127:0] r_work;
   logic         r_in_ready;
   logic         r_out_valid;
   logic         r_busy;

   logic [127:0] w_work_next;
   logic [1:0]   w_col_idx;

   //---------------------------------------------------------------------------
   // GF(2^8) helpers, using the reduction polynomial 0x11B. Every product is
   // built from one xtime chain (x2, x4, x8) of the input byte.
   //---------------------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a   [4];
      logic [7:0] x2  [4];
      logic [7:0] x4  [4];
      logic [7:0] x8  [4];
      logic [7:0] m09 [4];
      logic [7:0] m0b [4];
      logic [7:0] m0d [4];
      logic [7:0] m0e [4];
      logic [7:0] r   [4];
      for (int i = 0; i < 4; i++) begin
         a[i]   = col[31-8*i -: 8];
         x2[i]  = xtime(a[i]);
         x4[i]  = xtime(x2[i]);
         x8[i]  = xtime(x4[i]);
         m09[i] = x8[i] ^ a[i];
         m0b[i] = x8[i] ^ x2[i] ^ a[i];
         m0d[i] = x8[i] ^ x4[i] ^ a[i];
         m0e[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      r[0] = m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3];
      r[1] = m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3];
      r[2] = m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3];
      r[3] = m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3];
      return {r[0], r[1], r[2], r[3]};
   endfunction

   // Next working-register value: transform the columns selected by the
   // counter and leave the other columns untouched. The counter is always a
   // multiple of COLS_PER_CYCLE, so the selected index never passes column 3.
   always_comb begin
      w_work_next = r_work;
      w_col_idx   = 2'd0;
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         w_col_idx = r_col_cnt + 2'(j);
         w_work_next[32*w_col_idx +: 32] = inv_mix_col(r_work[32*w_col_idx +: 32]);
      end
   end

   // Control FSM, working register and registered handshake outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_col_cnt   <= 2'd0;
         r_work      <= 128'd0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_in_valid && r_in_ready) begin
                  r_work     <= i_din;
                  r_col_cnt  <= 2'd0;
                  r_state    <= ST_CALC;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_CALC: begin
               r_work <= w_work_next;
               if (r_col_cnt == LAST_COL_CNT) begin
                  // Column 3 is written in this cycle.
                  r_col_cnt   <= 2'd0;
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_col_cnt <= r_col_cnt + COL_STEP;
               end
            end
            ST_DONE: begin
               if (i_out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end else begin
                  r_state <= ST_DONE;
               end
            end
            default: begin
               // An unreachable encoding recovers to IDLE and drops the block.
               r_state     <= ST_IDLE;
               r_col_cnt   <= 2'd0;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_busy      = r_busy;
   assign o_dout      = r_work;

endmodule

// File: doc/inv_mix_columns_seq.md
Name: inv_mix_columns_seq

Overview:
Sequential AES InvMixColumns stage for the decryption datapath. It is the inverse of the combinational MixColumns used on the encryption side.
- Accepts one 128-bit state through a valid/ready handshake.
- Transforms COLS_PER_CYCLE columns per clock from a working register.
- Presents the result through an output valid/ready handshake.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the decrypt round.

Parameters:
COLS_PER_CYCLE, 1, columns transformed per CALC cycle; legal values 1, 2, 4. Any other value is an elaboration error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  din carries a state to transform
in_ready  output  1  block can accept a state
din  input  128  state in; column k = din[32k+31:32k]; row 0 = byte [32k+31:32k+24], row 3 = byte [32k+7:32k]
out_valid  output  1  dout holds a completed result
out_ready  input  1  downstream accepts dout
dout  output  128  transformed state; same byte/column layout as din
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, col_cnt=0, working register=0, in_ready=1, out_valid=0, busy=0, dout=0. Reset mid-CALC or mid-DONE discards the block with no output.
- Column transform, GF(2^8) with polynomial 0x11B. For input column bytes a0..a3 (row 0..3):
  - r0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3
  - r1 = 09·a0 ^ 0E·a1 ^ 0B·a2 ^ 0D·a3
  - r2 = 0D·a0 ^ 09·a1 ^ 0E·a2 ^ 0B·a3
  - r3 = 0B·a0 ^ 0D·a1 ^ 09·a2 ^ 0E·a3
  - Build all products from xtime chains. All intermediates are 8 bits wide.
- FSM: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready: load din into the working register, col_cnt=0, go to CALC.
  - CALC: each cycle, replace columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 in place and advance col_cnt by COLS_PER_CYCLE. After column 3 is written, go to DONE.
  - DONE: out_valid=1. When out_ready=1, go to IDLE and clear out_valid.
- Latency: out_valid rises 4/COLS_PER_CYCLE clock edges after the accepting edge (4, 2 or 1).
- Throughput: at most one block per 4/COLS_PER_CYCLE+2 cycles. No acceptance in CALC or DONE.
- in_ready is high only in IDLE. in_valid outside IDLE is ignored. din is sampled only on the accepting edge.
- dout is driven from the working register at all times and is meaningful only while out_valid=1. While out_valid=1 and out_ready=0, dout and out_valid stay stable.
- After the output handshake, dout keeps the last result until the next accept.
- out_ready is ignored outside DONE. If out_ready is held high continuously, DONE lasts exactly one cycle.
- Column order is 0 to 3, and col_cnt wraps to 0 on leaving CALC.

Test Plan:
- Known vectors, COLS_PER_CYCLE=1:
  - din = 8e4da1bc_9fdc589d_01010101_d5d5d7d6, out_ready=1.
  - Required: dout = db135345_f20a225c_01010101_d4d4d4d5.
  - out_valid high exactly 4 edges after accept; in_ready low for 5 cycles.
- Parameter sweep: repeat the known vectors at COLS_PER_CYCLE=2 and 4. Required: identical dout, latency 2 and 1 respectively.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: dout and out_valid stable, in_ready stays 0, a new in_valid pulse is ignored. Release out_ready: one-cycle handshake, then IDLE.
- Reset mid-operation: assert rst_n=0 in the second CALC cycle. Required, immediately without waiting for clk: out_valid=0, dout=0, in_ready=1, busy=0. The next block still produces the correct result.
- Round-trip: for 1000 random 128-bit states, feed the encrypt-side MixColumns output into the block. Required: dout equals the original state.
- Fixed points: all-0x00 → all-0x00; c6c6c6c6 in every column → unchanged.
